// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter: RAM word, RAM handshake state
// and arbiter grant state.
package cache_mem_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_D    = 2'd1,
      ARB_I    = 2'd2
   } arb_state_t;

   localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/response bundle between the icache/dcache pair and the
// memory arbiter. master = caches, slave = memory controller.
interface caches_if;
   import cache_mem_arbiter_pkg::*;

   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   logic  dREN;
   logic  dWEN;
   word_t daddr;
   word_t dstore;
   logic  dwait;
   word_t dload;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  iwait, iload, dwait, dload
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore,
      output iwait, iload, dwait, dload
   );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-ported RAM arbiter for icache reads and dcache reads/writes, with
// zero-cycle forwarding from IDLE and a bounded icache starvation window.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic      CLK,
   input  logic      nRST,
   caches_if.slave   ccif,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   arb_state_t    state, next_state, grant;
   logic [CW-1:0] starve_cnt, next_cnt;
   logic          d_req;
   logic          done;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= next_state;
         starve_cnt <= next_cnt;
      end
   end

   // Grant comes from the winner in IDLE and from the register otherwise; the
   // whole block is gated by nRST so enables drop asynchronously on reset.
   always_comb begin
      grant      = ARB_IDLE;
      next_state = ARB_IDLE;
      next_cnt   = starve_cnt;
      d_req      = ccif.dREN | ccif.dWEN;
      done       = (ramstate == ACCESS);

      ccif.iwait = 1'b1;
      ccif.dwait = 1'b1;
      ccif.iload = '0;
      ccif.dload = '0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;

      case (state)
         ARB_IDLE: begin
            if (ccif.iREN && starve_cnt == STARVE_LIM) grant = ARB_I;
            else if (d_req)                           grant = ARB_D;
            else if (ccif.iREN)                       grant = ARB_I;
         end
         ARB_D:   if (d_req)     grant = ARB_D;
         ARB_I:   if (ccif.iREN) grant = ARB_I;
         default: grant = ARB_IDLE;
      endcase

      if (!nRST) grant = ARB_IDLE;

      case (grant)
         ARB_D: begin
            ramaddr    = ccif.daddr;
            ramWEN     = ccif.dWEN;
            ramREN     = ccif.dREN & ~ccif.dWEN;
            ramstore   = ccif.dstore;
            ccif.dload = done ? ramload : '0;
            ccif.dwait = ~done;
            next_state = done ? ARB_IDLE : ARB_D;
         end
         ARB_I: begin
            ramaddr    = ccif.iaddr;
            ramREN     = 1'b1;
            ccif.iload = done ? ramload : '0;
            ccif.iwait = ~done;
            next_state = done ? ARB_IDLE : ARB_I;
         end
         default: next_state = ARB_IDLE;
      endcase

      if (!ccif.iREN)
         next_cnt = '0;
      else if (grant == ARB_I && done)
         next_cnt = '0;
      else if (grant == ARB_D && done && starve_cnt != STARVE_LIM)
         next_cnt = starve_cnt + CW'(1);
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle ownership model is
// compared on every falling edge, with literal checks pinning each scenario.
module tb_cache_mem_arbiter;
   import cache_mem_arbiter_pkg::*;

   localparam int STARVE = 4;
   localparam int OWN_NONE = 0;
   localparam int OWN_D    = 1;
   localparam int OWN_I    = 2;

   logic      CLK;
   logic      nRST;
   logic      ramREN, ramWEN;
   word_t     ramaddr, ramstore, ramload;
   ramstate_t ramstate;

   caches_if ccif ();

   cache_mem_arbiter #(.STARVE_MAX(STARVE)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .ccif     (ccif),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic  iwait, dwait, ren, wen;
      word_t addr, store, iload, dload;
      int    nxt_owner, nxt_streak;
   } exp_t;

   // Who owns the in-flight word, and how many data words in a row were
   // served while the icache kept asking.
   int m_owner  = OWN_NONE;
   int m_streak = 0;

   function automatic exp_t model();
      exp_t e;
      int   who;
      logic acc;
      e.iwait = 1'b1; e.dwait = 1'b1; e.ren = 1'b0; e.wen = 1'b0;
      e.addr = '0; e.store = '0; e.iload = '0; e.dload = '0;
      e.nxt_owner = OWN_NONE; e.nxt_streak = 0;
      if (!nRST) return e;
      acc = (ramstate == ACCESS);
      who = OWN_NONE;
      if (m_owner == OWN_D) begin
         if (ccif.dREN || ccif.dWEN) who = OWN_D;
      end else if (m_owner == OWN_I) begin
         if (ccif.iREN) who = OWN_I;
      end else begin
         if (ccif.iREN && m_streak >= STARVE) who = OWN_I;
         else if (ccif.dREN || ccif.dWEN)     who = OWN_D;
         else if (ccif.iREN)                  who = OWN_I;
      end
      if (who == OWN_D) begin
         e.addr  = ccif.daddr;
         e.store = ccif.dstore;
         e.wen   = ccif.dWEN;
         e.ren   = ccif.dREN && !ccif.dWEN;
         e.dwait = !acc;
         e.dload = acc ? ramload : 32'h0;
      end else if (who == OWN_I) begin
         e.addr  = ccif.iaddr;
         e.ren   = 1'b1;
         e.iwait = !acc;
         e.iload = acc ? ramload : 32'h0;
      end
      e.nxt_owner = (who != OWN_NONE && !acc) ? who : OWN_NONE;
      if (!ccif.iREN)                e.nxt_streak = 0;
      else if (who == OWN_I && acc)  e.nxt_streak = 0;
      else if (who == OWN_D && acc)  e.nxt_streak = (m_streak + 1 > STARVE) ? STARVE : m_streak + 1;
      else                           e.nxt_streak = m_streak;
      return e;
   endfunction

   always @(posedge CLK or negedge nRST) begin
      exp_t e;
      if (!nRST) begin
         m_owner  = OWN_NONE;
         m_streak = 0;
      end else begin
         e = model();
         m_owner  = e.nxt_owner;
         m_streak = e.nxt_streak;
      end
   end

   always @(negedge CLK) begin
      exp_t e;
      e = model();
      chk("iwait",    32'(ccif.iwait), 32'(e.iwait));
      chk("dwait",    32'(ccif.dwait), 32'(e.dwait));
      chk("ramREN",   32'(ramREN),     32'(e.ren));
      chk("ramWEN",   32'(ramWEN),     32'(e.wen));
      chk("ramaddr",  ramaddr,         e.addr);
      chk("ramstore", ramstore,        e.store);
      chk("iload",    ccif.iload,      e.iload);
      chk("dload",    ccif.dload,      e.dload);
      chk("en_excl",  32'(ramREN & ramWEN), 32'h0);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      ccif.iREN = 1'b0; ccif.iaddr = '0;
      ccif.dREN = 1'b0; ccif.dWEN = 1'b0; ccif.daddr = '0; ccif.dstore = '0;
      ramstate = FREE; ramload = '0;
   endtask

   task automatic idle();
      clear_inputs();
      mid();
      chk("idle_ramREN", 32'(ramREN), 32'h0);
      tick();
   endtask

   initial begin
      nRST = 1'b0;
      clear_inputs();
      mid();
      chk("rst_iwait",   32'(ccif.iwait), 32'h1);
      chk("rst_dwait",   32'(ccif.dwait), 32'h1);
      chk("rst_ramREN",  32'(ramREN),     32'h0);
      chk("rst_ramWEN",  32'(ramWEN),     32'h0);
      chk("rst_ramaddr", ramaddr,         32'h0);
      chk("rst_iload",   ccif.iload,      32'h0);
      #1 nRST = 1'b1;
      tick();

      // icache alone, two BUSY cycles then ACCESS
      ccif.iREN = 1'b1; ccif.iaddr = 32'h40; ramstate = BUSY; ramload = 32'h8C22_0004;
      mid();
      chk("i_c0_ramREN",  32'(ramREN), 32'h1);
      chk("i_c0_ramaddr", ramaddr,     32'h40);
      chk("i_c0_iwait",   32'(ccif.iwait), 32'h1);
      tick();
      mid();
      chk("i_c1_iwait",   32'(ccif.iwait), 32'h1);
      tick();
      ramstate = ACCESS;
      mid();
      chk("i_c2_iwait", 32'(ccif.iwait), 32'h0);
      chk("i_c2_iload", ccif.iload,      32'h8C22_0004);
      tick();
      idle();

      // simultaneous requests: data first, instruction right after
      ccif.iREN = 1'b1; ccif.iaddr = 32'h44;
      ccif.dREN = 1'b1; ccif.daddr = 32'h3100; ramstate = BUSY; ramload = 32'h1111_2222;
      mid();
      chk("s_c0_ramaddr", ramaddr, 32'h3100);
      chk("s_c0_dwait",   32'(ccif.dwait), 32'h1);
      tick();
      ramstate = ACCESS;
      mid();
      chk("s_c1_dwait", 32'(ccif.dwait), 32'h0);
      chk("s_c1_dload", ccif.dload,      32'h1111_2222);
      chk("s_c1_iwait", 32'(ccif.iwait), 32'h1);
      tick();
      ccif.dREN = 1'b0; ramstate = BUSY;
      mid();
      chk("s_c2_ramaddr", ramaddr,     32'h44);
      chk("s_c2_ramREN",  32'(ramREN), 32'h1);
      tick();
      ramstate = ACCESS;
      mid();
      chk("s_c3_iwait", 32'(ccif.iwait), 32'h0);
      tick();
      idle();

      // starvation bound: D D D D I repeating
      ccif.iREN = 1'b1; ccif.iaddr = 32'h80;
      ccif.dREN = 1'b1; ccif.daddr = 32'h500; ramstate = ACCESS; ramload = 32'h5555_AAAA;
      for (int k = 0; k < 10; k++) begin
         mid();
         if (k % 5 == 4) begin
            chk("starve_iwait", 32'(ccif.iwait), 32'h0);
            chk("starve_dwait", 32'(ccif.dwait), 32'h1);
            chk("starve_addr",  ramaddr,         32'h80);
         end else begin
            chk("starve_dwait", 32'(ccif.dwait), 32'h0);
            chk("starve_iwait", 32'(ccif.iwait), 32'h1);
            chk("starve_addr",  ramaddr,         32'h500);
         end
         tick();
      end
      idle();

      // dcache write
      ccif.dWEN = 1'b1; ccif.daddr = 32'h200; ccif.dstore = 32'hDEAD_BEEF; ramstate = BUSY;
      mid();
      chk("w_c0_ramWEN",   32'(ramWEN), 32'h1);
      chk("w_c0_ramREN",   32'(ramREN), 32'h0);
      chk("w_c0_ramstore", ramstore,    32'hDEAD_BEEF);
      chk("w_c0_dwait",    32'(ccif.dwait), 32'h1);
      tick();
      ramstate = ACCESS;
      mid();
      chk("w_c1_dwait", 32'(ccif.dwait), 32'h0);
      tick();
      ccif.dREN = 1'b1;
      mid();
      chk("rw_ramREN", 32'(ramREN), 32'h0);
      chk("rw_ramWEN", 32'(ramWEN), 32'h1);
      tick();
      idle();

      // data request abandoned mid-grant, then pending icache with RAM error retry
      ccif.dREN = 1'b1; ccif.daddr = 32'h600;
      ccif.iREN = 1'b1; ccif.iaddr = 32'h88; ramstate = BUSY; ramload = 32'h0BAD_F00D;
      mid();
      chk("a_c0_ramaddr", ramaddr,     32'h600);
      chk("a_c0_ramREN",  32'(ramREN), 32'h1);
      tick();
      ccif.dREN = 1'b0;
      mid();
      chk("a_c1_ramREN", 32'(ramREN),     32'h0);
      chk("a_c1_dwait",  32'(ccif.dwait), 32'h1);
      tick();
      mid();
      chk("a_c2_ramaddr", ramaddr,     32'h88);
      chk("a_c2_ramREN",  32'(ramREN), 32'h1);
      tick();
      ramstate = ERROR;
      mid();
      chk("a_err_iwait",  32'(ccif.iwait), 32'h1);
      chk("a_err_ramREN", 32'(ramREN),     32'h1);
      tick();
      ramstate = ACCESS;
      mid();
      chk("a_c4_iwait", 32'(ccif.iwait), 32'h0);
      chk("a_c4_iload", ccif.iload,      32'h0BAD_F00D);
      tick();
      idle();

      // asynchronous reset in the middle of an icache grant
      ccif.iREN = 1'b1; ccif.iaddr = 32'h90; ramstate = BUSY;
      mid();
      chk("r_c0_ramREN", 32'(ramREN), 32'h1);
      tick();
      #2 nRST = 1'b0;
      #1;
      chk("r_async_ramREN",  32'(ramREN),     32'h0);
      chk("r_async_iwait",   32'(ccif.iwait), 32'h1);
      chk("r_async_dwait",   32'(ccif.dwait), 32'h1);
      chk("r_async_ramaddr", ramaddr,         32'h0);
      mid();
      #1;
      nRST = 1'b1; ccif.iaddr = 32'h94; ramstate = ACCESS; ramload = 32'hCAFE_F00D;
      tick();
      mid();
      chk("r_post_ramREN",  32'(ramREN),     32'h1);
      chk("r_post_ramaddr", ramaddr,         32'h94);
      chk("r_post_iwait",   32'(ccif.iwait), 32'h0);
      chk("r_post_iload",   ccif.iload,      32'hCAFE_F00D);
      tick();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
